// File: rtl/q_meter_if.sv
// Bus bundle between a measurement controller (master) and q_meter (slave):
// DAC drive, ADC sample stream and measurement result.
interface q_meter_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 enable;
  logic [BUS_WIDTH-1:0] i_ref;
  logic [BUS_WIDTH-1:0] offset;
  logic [BUS_WIDTH-1:0] adc_data;
  logic                 adc_valid;
  logic [BUS_WIDTH-1:0] dac_code;
  logic                 dac_load;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 ready;
  logic                 timeout;

  modport master (
    output enable, i_ref, offset, adc_data, adc_valid,
    input  dac_code, dac_load, q_measured, ready, timeout
  );

  modport slave (
    input  enable, i_ref, offset, adc_data, adc_valid,
    output dac_code, dac_load, q_measured, ready, timeout
  );
endinterface

// File: rtl/q_meter.sv
// Charge meter: drives a DAC code, waits for settling, averages 2**LOG2_SAMPLES
// ADC samples and reports avg - offset. Define Q_METER_SAT_EN to clamp at 0.
module q_meter #(
  parameter int BUS_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOG2_SAMPLES  = 3,
  parameter int TIMEOUT       = 255
) (
  input  logic     clk,
  input  logic     rst,
  q_meter_if.slave bus
);

  localparam int AccW = BUS_WIDTH + LOG2_SAMPLES;
  localparam int CntW = LOG2_SAMPLES + 1;
  localparam int SetW = $clog2(SETTLE_CYCLES + 1);
  localparam int ToW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] LastSample = CntW'((1 << LOG2_SAMPLES) - 1);
  localparam logic [SetW-1:0] SettleInit = SetW'(SETTLE_CYCLES);
  localparam logic [ToW-1:0]  ToLast     = ToW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, ACQ, DONE} state_t;

  state_t               state_q;
  logic [AccW-1:0]      acc_q;
  logic [CntW-1:0]      sampleCnt_q;
  logic [SetW-1:0]      settleCnt_q;
  logic [ToW-1:0]       toCnt_q;
  logic [BUS_WIDTH-1:0] dacCode_q;
  logic                 dacLoad_q;
  logic [BUS_WIDTH-1:0] qMeas_q;
  logic                 ready_q;
  logic                 timeout_q;

  logic [BUS_WIDTH-1:0] avg;
  logic [BUS_WIDTH-1:0] result_d;

  assign avg = acc_q[AccW-1:LOG2_SAMPLES];

  always_comb begin
    result_d = avg - bus.offset;
`ifdef Q_METER_SAT_EN
    if (bus.offset > avg) result_d = '0;
`endif
  end

  // Dropping enable aborts LOAD/SETTLE/ACQ; DONE always finishes its result
  // and only then chooses between LOAD and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sampleCnt_q <= '0;
      settleCnt_q <= '0;
      toCnt_q     <= '0;
      dacCode_q   <= '0;
      dacLoad_q   <= 1'b0;
      qMeas_q     <= '0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      dacLoad_q <= 1'b0;
      ready_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable) state_q <= LOAD;
        end
        LOAD: begin
          if (!bus.enable) begin
            state_q <= IDLE;
          end else begin
            dacCode_q   <= bus.i_ref;
            dacLoad_q   <= 1'b1;
            acc_q       <= '0;
            sampleCnt_q <= '0;
            toCnt_q     <= '0;
            settleCnt_q <= SettleInit;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          if (!bus.enable) begin
            state_q <= IDLE;
          end else begin
            settleCnt_q <= settleCnt_q - SetW'(1);
            if (settleCnt_q == SetW'(1)) state_q <= ACQ;
          end
        end
        ACQ: begin
          if (!bus.enable) begin
            state_q <= IDLE;
          end else if (bus.adc_valid) begin
            acc_q       <= acc_q + AccW'(bus.adc_data);
            sampleCnt_q <= sampleCnt_q + CntW'(1);
            toCnt_q     <= '0;
            if (sampleCnt_q == LastSample) state_q <= DONE;
          end else if (toCnt_q == ToLast) begin
            timeout_q   <= 1'b1;
            acc_q       <= '0;
            sampleCnt_q <= '0;
            state_q     <= LOAD;
          end else begin
            toCnt_q <= toCnt_q + ToW'(1);
          end
        end
        DONE: begin
          qMeas_q <= result_d;
          ready_q <= 1'b1;
          state_q <= bus.enable ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dac_code   = dacCode_q;
  assign bus.dac_load   = dacLoad_q;
  assign bus.q_measured = qMeas_q;
  assign bus.ready      = ready_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_q_meter.sv
// Directed testbench for q_meter with default parameters; expected results
// are hand-computed averages of the sample vectors driven below.
`timescale 1ns/1ps
module tb_q_meter;
  localparam int BW     = 10;
  localparam int SETTLE = 16;
  localparam int TO     = 255;
`ifdef Q_METER_SAT_EN
  localparam logic [BW-1:0] ExpOff = 10'd0;
`else
  localparam logic [BW-1:0] ExpOff = 10'd1014;
`endif

  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int readyCnt = 0;
  int loadCnt = 0;

  q_meter_if #(.BUS_WIDTH(BW)) bus();

  q_meter #(
    .BUS_WIDTH(BW), .SETTLE_CYCLES(SETTLE), .LOG2_SAMPLES(3), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ready)    readyCnt <= readyCnt + 1;
    if (bus.dac_load) loadCnt  <= loadCnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startRun(input logic [BW-1:0] iref, output bit ok);
    bus.i_ref  = iref;
    bus.enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dac_load) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle(input bit junk, input logic [BW-1:0] v);
    bus.adc_valid = junk;
    bus.adc_data  = v;
    repeat (SETTLE) step();
    bus.adc_valid = 1'b0;
  endtask

  task automatic sendSample(input logic [BW-1:0] v);
    bus.adc_data  = v;
    bus.adc_valid = 1'b1;
    step();
    bus.adc_valid = 1'b0;
  endtask

  task automatic waitReady(input int maxCyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      step();
      if (bus.ready) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic goIdle();
    bus.enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.i_ref = '0; bus.offset = '0;
    bus.adc_data = '0; bus.adc_valid = 1'b0;
    repeat (3) step();
    checks++; if (bus.dac_code !== 10'd0) begin errors++; $display("[TB] FAIL reset_dac_code: got %0d expected 0", bus.dac_code); end
    checks++; if (bus.dac_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_dac_load: got %0b expected 0", bus.dac_load); end
    checks++; if (bus.q_measured !== 10'd0) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", bus.q_measured); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", bus.ready); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %0b expected 0", bus.timeout); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    int ld0 = loadCnt;
    int rd0 = readyCnt;
    startRun(10'd300, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_load_seen: got %0b expected 1", ok); end
    checks++; if (bus.dac_code !== 10'd300) begin errors++; $display("[TB] FAIL basic_dac_code: got %0d expected 300", bus.dac_code); end
    settle(1'b0, '0);
    for (int i = 0; i < 8; i++) sendSample(BW'(100 + i));
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_early: got %0b expected 0", bus.ready); end
    step();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_latency: got %0b expected 1", bus.ready); end
    checks++; if (bus.q_measured !== 10'd103) begin errors++; $display("[TB] FAIL basic_q: got %0d expected 103", bus.q_measured); end
    checks++; if (loadCnt - ld0 !== 1) begin errors++; $display("[TB] FAIL basic_load_count: got %0d expected 1", loadCnt - ld0); end
    step();
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_width: got %0b expected 0", bus.ready); end
    goIdle();
    checks++; if (readyCnt - rd0 !== 1) begin errors++; $display("[TB] FAIL basic_ready_count: got %0d expected 1", readyCnt - rd0); end
  endtask

  task automatic test_settle_ignore();
    bit ok, seen;
    startRun(10'd300, ok);
    settle(1'b1, 10'd1023);
    for (int i = 0; i < 8; i++) sendSample(10'd50);
    waitReady(5, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL settle_ready: got %0b expected 1", seen); end
    checks++; if (bus.q_measured !== 10'd50) begin errors++; $display("[TB] FAIL settle_q: got %0d expected 50", bus.q_measured); end
    goIdle();
  endtask

  task automatic test_offset();
    bit ok, seen;
    bus.offset = 10'd60;
    startRun(10'd300, ok);
    settle(1'b0, '0);
    for (int i = 0; i < 8; i++) sendSample(10'd50);
    waitReady(5, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL offset_ready: got %0b expected 1", seen); end
    checks++; if (bus.q_measured !== ExpOff) begin errors++; $display("[TB] FAIL offset_q: got %0d expected %0d", bus.q_measured, ExpOff); end
    goIdle();
    bus.offset = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    int waited = -1;
    int rd0 = readyCnt;
    startRun(10'd300, ok);
    settle(1'b0, '0);
    for (int i = 0; i < 3; i++) sendSample(10'd77);
    repeat (250) step();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got %0b expected 0", bus.timeout); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.timeout === 1'b1) begin
        waited = 251 + i;
        break;
      end
    end
    checks++; if (waited !== TO) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", waited, TO); end
    checks++; if (bus.q_measured !== ExpOff) begin errors++; $display("[TB] FAIL timeout_q_held: got %0d expected %0d", bus.q_measured, ExpOff); end
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.dac_load) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL timeout_reload: got %0b expected 1", ok); end
    goIdle();
    checks++; if (readyCnt - rd0 !== 0) begin errors++; $display("[TB] FAIL timeout_no_ready: got %0d expected 0", readyCnt - rd0); end
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %0b expected 1", bus.timeout); end
  endtask

  task automatic test_abort();
    bit ok, seen;
    int rd0 = readyCnt;
    int ld0;
    startRun(10'd300, ok);
    settle(1'b0, '0);
    for (int i = 0; i < 4; i++) sendSample(10'd9);
    bus.i_ref = 10'd999;
    step();
    ld0 = loadCnt;
    bus.enable = 1'b0;
    repeat (20) step();
    checks++; if (readyCnt - rd0 !== 0) begin errors++; $display("[TB] FAIL abort_no_ready: got %0d expected 0", readyCnt - rd0); end
    checks++; if (loadCnt - ld0 !== 0) begin errors++; $display("[TB] FAIL abort_idle: got %0d loads expected 0", loadCnt - ld0); end
    checks++; if (bus.dac_code !== 10'd300) begin errors++; $display("[TB] FAIL abort_dac_held: got %0d expected 300", bus.dac_code); end
    checks++; if (bus.q_measured !== ExpOff) begin errors++; $display("[TB] FAIL abort_q_held: got %0d expected %0d", bus.q_measured, ExpOff); end
    startRun(10'd500, ok);
    checks++; if (bus.dac_code !== 10'd500) begin errors++; $display("[TB] FAIL abort_new_dac: got %0d expected 500", bus.dac_code); end
    settle(1'b0, '0);
    for (int i = 0; i < 8; i++) sendSample(BW'(200 + i));
    waitReady(5, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL abort_rerun_ready: got %0b expected 1", seen); end
    checks++; if (bus.q_measured !== 10'd203) begin errors++; $display("[TB] FAIL abort_rerun_q: got %0d expected 203", bus.q_measured); end
    goIdle();
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int rd0;
    startRun(10'd700, ok);
    settle(1'b0, '0);
    for (int i = 0; i < 4; i++) sendSample(10'd5);
    rst = 1'b1;
    #1;
    checks++; if (bus.dac_code !== 10'd0) begin errors++; $display("[TB] FAIL rstmid_dac_code: got %0d expected 0", bus.dac_code); end
    checks++; if (bus.q_measured !== 10'd0) begin errors++; $display("[TB] FAIL rstmid_q: got %0d expected 0", bus.q_measured); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_timeout: got %0b expected 0", bus.timeout); end
    checks++; if ({bus.ready, bus.dac_load} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_strobes: got %0b expected 00", {bus.ready, bus.dac_load}); end
    step();
    rst = 1'b0;
    rd0 = readyCnt;
    startRun(10'd400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_load_seen: got %0b expected 1", ok); end
    checks++; if (readyCnt - rd0 !== 0) begin errors++; $display("[TB] FAIL rstmid_early_ready: got %0d expected 0", readyCnt - rd0); end
    checks++; if (bus.dac_code !== 10'd400) begin errors++; $display("[TB] FAIL rstmid_dac_code_new: got %0d expected 400", bus.dac_code); end
    settle(1'b0, '0);
    for (int i = 0; i < 8; i++) sendSample(10'd10);
    waitReady(5, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %0b expected 1", seen); end
    checks++; if (bus.q_measured !== 10'd10) begin errors++; $display("[TB] FAIL rstmid_q_new: got %0d expected 10", bus.q_measured); end
    goIdle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete within 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_settle_ignore();
    test_offset();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
